kicp_mem_responder: RTL and testbench

Memory-side responder for the accelerator memory handshake (`mem_operation` / `mem_opdone`) used by the KICP compute blocks. It accepts single-word read and write requests from one accelerator master and converts them into strobes for a single-port SRAM macro with a configurable read latency. It returns read data and a one-cycle `mem_opdone` pulse per request, and it flags illegal requests in a sticky error bit.

---
 rtl/kicp_mem_responder.sv | 154 +++++++++++++++
 tb/tb_kicp_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kicp_mem_responder.sv
// kicp_mem_responder: turns single-word read/write requests from one
// accelerator master into one-cycle strobes for a single-port SRAM macro,
// returns read data with a one-cycle mem_opdone pulse, and records illegal
// requests in a sticky error flag. All outputs are registered.

`ifndef KICP_SRAM_AWIDTH
`define KICP_SRAM_AWIDTH 8
`endif

module kicp_mem_responder #(
    parameter int AWIDTH       = `KICP_SRAM_AWIDTH,
    parameter int MEM_WORDS    = 256,
    parameter int SRAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mem_operation,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              mem_opdone,
    output logic              err_o,
    input  logic              err_clr,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [3:0]        sram_wmask,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout
);

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, GAP} state_t;

    // Wide enough that neither the address nor MEM_WORDS can wrap in the compare.
    localparam int CMP_W = AWIDTH + 33;
    typedef logic [CMP_W-1:0] cmp_t;
    localparam logic [2:0] LAT_LOAD = 3'(SRAM_LATENCY - 1);

    state_t            state, state_next;
    logic              write_reg, write_next;   // latched request is a write (op 11)
    logic              bad_reg, bad_next;       // latched request is illegal
    logic [2:0]        cnt_reg, cnt_next;
    logic [31:0]       data_next;
    logic              opdone_next;
    logic              err_next;
    logic              csb_next, web_next;
    logic [3:0]        wmask_next;
    logic [AWIDTH-1:0] addr_next;
    logic [31:0]       din_next;

    logic in_range;
    logic req_legal;

    // Only op 01 and 11 (bit 0 set) to an implemented word are legal.
    assign in_range  = cmp_t'(addr_i) < cmp_t'(MEM_WORDS);
    assign req_legal = in_range && mem_operation[0];

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        state_next  = state;
        write_next  = write_reg;
        bad_next    = bad_reg;
        cnt_next    = cnt_reg;
        data_next   = data_o;
        opdone_next = 1'b0;
        err_next    = err_clr ? 1'b0 : err_o;
        csb_next    = sram_csb;
        web_next    = sram_web;
        wmask_next  = sram_wmask;
        addr_next   = sram_addr;
        din_next    = sram_din;
        case (state)
            IDLE: begin
                if (mem_operation != 2'b00) begin
                    state_next = ACCESS;
                    write_next = (mem_operation == 2'b11);
                    bad_next   = !req_legal;
                    if (req_legal) begin
                        csb_next  = 1'b0;
                        addr_next = addr_i;
                        if (mem_operation == 2'b11) begin
                            web_next   = 1'b0;
                            din_next   = data_i;
                            wmask_next = 4'hF;
                        end
                    end else begin
                        // A new error overrides a simultaneous clear.
                        err_next = 1'b1;
                    end
                end
            end
            ACCESS: begin
                csb_next   = 1'b1;
                web_next   = 1'b1;
                wmask_next = 4'h0;
                if (bad_reg || write_reg) begin
                    state_next  = RESP;
                    opdone_next = 1'b1;
                    // Illegal reads (out-of-range 01, reserved 10) return zero.
                    if (bad_reg && !write_reg) begin
                        data_next = '0;
                    end
                end else begin
                    state_next = WAIT;
                    cnt_next   = LAT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd0) begin
                    data_next   = sram_dout;
                    opdone_next = 1'b1;
                    state_next  = RESP;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            RESP:    state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset forces an idle, strobe-free SRAM side.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            write_reg  <= 1'b0;
            bad_reg    <= 1'b0;
            cnt_reg    <= 3'd0;
            data_o     <= '0;
            mem_opdone <= 1'b0;
            err_o      <= 1'b0;
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_wmask <= 4'h0;
            sram_addr  <= '0;
            sram_din   <= '0;
        end else begin
            state      <= state_next;
            write_reg  <= write_next;
            bad_reg    <= bad_next;
            cnt_reg    <= cnt_next;
            data_o     <= data_next;
            mem_opdone <= opdone_next;
            err_o      <= err_next;
            sram_csb   <= csb_next;
            sram_web   <= web_next;
            sram_wmask <= wmask_next;
            sram_addr  <= addr_next;
            sram_din   <= din_next;
        end
    end

endmodule

// File: tb/tb_kicp_mem_responder.sv
// Bench for kicp_mem_responder: two instances (SRAM latency 1 and 3), each with
// an SRAM macro model, checked every cycle against a transaction-level model.

module tb_kicp_mem_responder;

    localparam int AW = 8;
    localparam int MW = 192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    op     [2];
    logic [AW-1:0] addr   [2];
    logic [31:0]   wdata  [2];
    logic          clr    [2];
    logic [31:0]   rdata  [2];
    logic          done   [2];
    logic          err    [2];
    logic          csb    [2];
    logic          web    [2];
    logic [3:0]    wmask  [2];
    logic [AW-1:0] saddr  [2];
    logic [31:0]   sdin   [2];
    logic [31:0]   sdout  [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int k);
        return 32'hC0DE0000 ^ (32'(k) * 32'h00010203);
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : 3;

            kicp_mem_responder #(
                .AWIDTH(AW), .MEM_WORDS(MW), .SRAM_LATENCY(L)
            ) u_dut (
                .clk(clk), .reset_n(rst_n), .mem_operation(op[gi]),
                .addr_i(addr[gi]), .data_i(wdata[gi]), .data_o(rdata[gi]),
                .mem_opdone(done[gi]), .err_o(err[gi]), .err_clr(clr[gi]),
                .sram_csb(csb[gi]), .sram_web(web[gi]), .sram_wmask(wmask[gi]),
                .sram_addr(saddr[gi]), .sram_din(sdin[gi]), .sram_dout(sdout[gi])
            );

            logic [31:0] smem [256];
            logic [31:0] pd   [8];
            logic [7:0]  pv;

            // SRAM macro: masked write on capture edge, read data valid L edges later
            always @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < 256; k++) smem[k] <= init_word(k);
                    pv <= '0;
                end else begin
                    pv    <= {pv[6:0], (!csb[gi] && web[gi])};
                    pd[0] <= smem[saddr[gi]];
                    for (int k = 1; k < 8; k++) pd[k] <= pd[k-1];
                    if (!csb[gi] && !web[gi]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wmask[gi][b]) smem[saddr[gi]][8*b +: 8] <= sdin[gi][8*b +: 8];
                        end
                    end
                end
            end
            assign sdout[gi] = pv[L-1] ? pd[L-1] : 32'hBADC0DE5;
        end
    endgenerate

    // Transaction-level reference model state
    int          cyc;
    int          ready_at  [2];
    int          strobe_at [2];
    int          done_at   [2];
    bit          t_legal   [2];
    bit          t_write   [2];
    bit          t_upd     [2];
    logic [31:0] t_rdata   [2];
    logic [31:0] e_data    [2];
    logic [31:0] e_din     [2];
    logic [AW-1:0] e_addr  [2];
    bit          e_err     [2];
    logic [31:0] ref_mem   [2][256];
    int          strobes   [2];
    int          n_checks;
    int          n_errors;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, i, cyc, act, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at that edge, compare.
    task automatic step();
        logic [1:0]    p_op   [2];
        logic [AW-1:0] p_addr [2];
        logic [31:0]   p_data [2];
        logic          p_clr  [2];
        bit legal, nw, strobe;
        for (int i = 0; i < 2; i++) begin
            p_op[i] = op[i]; p_addr[i] = addr[i]; p_data[i] = wdata[i]; p_clr[i] = clr[i];
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                ready_at[i] = 0; strobe_at[i] = -100; done_at[i] = -100;
                t_legal[i] = 0; t_write[i] = 0; t_upd[i] = 0; t_rdata[i] = '0;
                e_data[i] = '0; e_din[i] = '0; e_addr[i] = '0; e_err[i] = 0;
                for (int k = 0; k < 256; k++) ref_mem[i][k] = init_word(k);
            end else begin
                nw = (cyc - 1 >= ready_at[i]) && (p_op[i] != 2'b00);
                if (nw) begin
                    legal        = p_op[i][0] && (int'(p_addr[i]) < MW);
                    t_legal[i]   = legal;
                    t_write[i]   = (p_op[i] == 2'b11);
                    strobe_at[i] = cyc;
                    done_at[i]   = (legal && !t_write[i]) ? cyc + 1 + lat_of(i) : cyc + 1;
                    ready_at[i]  = done_at[i] + 2;
                    t_upd[i]     = !t_write[i];
                    t_rdata[i]   = legal ? ref_mem[i][p_addr[i]] : 32'h0;
                    if (legal) begin
                        e_addr[i] = p_addr[i];
                        if (t_write[i]) begin
                            e_din[i] = p_data[i];
                            ref_mem[i][p_addr[i]] = p_data[i];
                        end
                    end
                    if (!legal) e_err[i] = 1;
                    else if (p_clr[i]) e_err[i] = 0;
                end else if (p_clr[i]) begin
                    e_err[i] = 0;
                end
                if (cyc == done_at[i] && t_upd[i]) e_data[i] = t_rdata[i];
            end
            strobe = (cyc == strobe_at[i]) && t_legal[i];
            chk("data_o", i, rdata[i], e_data[i]);
            chk("mem_opdone", i, 32'(done[i]), 32'(cyc == done_at[i]));
            chk("err_o", i, 32'(err[i]), 32'(e_err[i]));
            chk("sram_csb", i, 32'(csb[i]), 32'(!strobe));
            chk("sram_web", i, 32'(web[i]), 32'(!(strobe && t_write[i])));
            chk("sram_wmask", i, 32'(wmask[i]), (strobe && t_write[i]) ? 32'hF : 32'h0);
            chk("sram_addr", i, 32'(saddr[i]), 32'(e_addr[i]));
            chk("sram_din", i, sdin[i], e_din[i]);
            if (!csb[i]) strobes[i]++;
        end
    endtask

    task automatic wait_ready(input int i);
        for (int k = 0; k < 40 && cyc < ready_at[i]; k++) step();
    endtask

    // One request: op held for 'hold' cycles, addr/data scrambled after sampling.
    task automatic do_req(input int i, input logic [1:0] o, input logic [AW-1:0] a,
                          input logic [31:0] d, input int hold,
                          output logic [31:0] r, output int lat);
        int n;
        bit found;
        wait_ready(i);
        op[i] = o; addr[i] = a; wdata[i] = d;
        n = cyc; found = 0; r = '0; lat = -1;
        for (int k = 0; k < 30; k++) begin
            step();
            clr[i] = 1'b0;
            if (cyc - n >= hold) op[i] = 2'b00;
            addr[i]  = 8'($urandom_range(0, 255));
            wdata[i] = $urandom;
            if (done[i]) begin
                lat = cyc - n; r = rdata[i]; op[i] = 2'b00; found = 1;
                break;
            end
        end
        if (!found) begin
            n_checks++; n_errors++;
            $display("FAIL req_timeout dut%0d: got no mem_opdone, expected one within 30 cycles", i);
        end
        $display("txn dut%0d op=%b addr=%h wdata=%h latency=%0d data_o=%h err_o=%b",
                 i, o, a, d, lat, r, err[i]);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] got [5];
        int lat, s0, pulses;

        for (int i = 0; i < 2; i++) begin
            op[i] = 2'b00; addr[i] = '0; wdata[i] = '0; clr[i] = 1'b0; strobes[i] = 0;
        end
        n_checks = 0; n_errors = 0; cyc = 0;

        // Reset state
        repeat (3) step();
        #2 rst_n = 1'b1;
        repeat (2) step();

        // Write then read, latency 1
        s0 = strobes[0];
        do_req(0, 2'b11, 8'd5, 32'hDEADBEEF, 1, r, lat);
        chk("wr_latency", 0, 32'(lat), 32'd2);
        chk("wr_strobes", 0, 32'(strobes[0] - s0), 32'd1);
        do_req(0, 2'b01, 8'd5, 32'h0, 1, r, lat);
        chk("rd_latency", 0, 32'(lat), 32'd3);
        chk("rd_data", 0, r, 32'hDEADBEEF);

        // Latency 3, op dropped in cycle n+2, then a write must not touch data_o
        do_req(1, 2'b11, 8'd9, 32'h12345678, 1, r, lat);
        do_req(1, 2'b01, 8'd9, 32'h0, 2, r, lat);
        chk("l3_rd_latency", 1, 32'(lat), 32'd5);
        chk("l3_rd_data", 1, r, 32'h12345678);
        do_req(1, 2'b11, 8'd10, 32'hFFFF0000, 1, r, lat);
        chk("l3_wr_keeps_data", 1, rdata[1], 32'h12345678);

        // Held read with incrementing address
        do_req(0, 2'b11, 8'd0, 32'd3, 1, r, lat);
        do_req(0, 2'b11, 8'd1, 32'd2, 1, r, lat);
        do_req(0, 2'b11, 8'd2, 32'd3, 1, r, lat);
        do_req(0, 2'b11, 8'd3, 32'd2, 1, r, lat);
        wait_ready(0);
        s0 = strobes[0]; pulses = 0;
        op[0] = 2'b01; addr[0] = 8'd0;
        for (int k = 0; k < 80 && pulses < 5; k++) begin
            step();
            if (done[0]) begin
                got[pulses] = rdata[0];
                $display("txn dut0 held read #%0d data_o=%h", pulses, rdata[0]);
                pulses++;
                addr[0] = addr[0] + 8'd1;
                if (pulses == 5) op[0] = 2'b00;
            end
        end
        op[0] = 2'b00;
        chk("held_pulses", 0, 32'(pulses), 32'd5);
        chk("held_strobes", 0, 32'(strobes[0] - s0), 32'd5);
        chk("held_d0", 0, got[0], 32'd3);
        chk("held_d1", 0, got[1], 32'd2);
        chk("held_d2", 0, got[2], 32'd3);
        chk("held_d3", 0, got[3], 32'd2);
        chk("held_d4", 0, got[4], init_word(4));

        // Errors
        wait_ready(0);
        s0 = strobes[0];
        do_req(0, 2'b01, 8'(MW), 32'h0, 1, r, lat);
        chk("oor_data", 0, r, 32'h0);
        chk("oor_err", 0, 32'(err[0]), 32'd1);
        chk("oor_strobes", 0, 32'(strobes[0] - s0), 32'd0);
        s0 = strobes[0];
        do_req(0, 2'b10, 8'd7, 32'h0, 1, r, lat);
        chk("rsv_strobes", 0, 32'(strobes[0] - s0), 32'd0);
        wait_ready(0);
        clr[0] = 1'b0;
        step();
        clr[0] = 1'b1;
        do_req(0, 2'b11, 8'd200, 32'hAAAA5555, 1, r, lat);
        chk("clr_vs_set_err", 0, 32'(err[0]), 32'd1);
        wait_ready(0);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("clr_err", 0, 32'(err[0]), 32'd0);

        // Asynchronous reset in the middle of a read strobe
        do_req(0, 2'b10, 8'd1, 32'h0, 1, r, lat);
        do_req(0, 2'b01, 8'd5, 32'h0, 1, r, lat);
        wait_ready(0);
        op[0] = 2'b01; addr[0] = 8'd5;
        step();
        op[0] = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_csb", 0, 32'(csb[0]), 32'd1);
        chk("rst_web", 0, 32'(web[0]), 32'd1);
        chk("rst_opdone", 0, 32'(done[0]), 32'd0);
        chk("rst_data", 0, rdata[0], 32'h0);
        chk("rst_err", 0, 32'(err[0]), 32'd0);
        chk("rst_addr", 0, 32'(saddr[0]), 32'h0);
        repeat (3) step();
        #2 rst_n = 1'b1;
        s0 = strobes[0];
        repeat (3) step();
        chk("post_rst_idle", 0, 32'(strobes[0] - s0), 32'd0);

        // Randomized traffic on both instances
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                case ($urandom_range(0, 7))
                    0, 1, 2: op[i] = 2'b00;
                    3, 4:    op[i] = 2'b01;
                    5, 6:    op[i] = 2'b11;
                    default: op[i] = 2'b10;
                endcase
                addr[i]  = 8'($urandom_range(0, 255));
                wdata[i] = $urandom;
                clr[i]   = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            op[i] = 2'b00; clr[i] = 1'b0;
        end
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
